// File: rtl/instruction_executor.sv
// -----------------------------------------------------------------------------
// instruction_executor
//   Consumer end of the fetch unit's instruction stream. Requests one
//   instruction at a time, latches it, decodes and executes it against a
//   32-entry register file, and writes the result back. It does not pipeline,
//   so each instruction takes 4 cycles: REQ, DECODE, EXEC and WB.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   run          level; 1 = keep executing, 0 = stop after current instruction
//   instruction  fetch unit word, valid in the cycle after fetch_en
//   fetch_en     fetch request, high for exactly one cycle per instruction
//   busy         high in every state except IDLE
//   wb_valid     one-cycle write-back pulse; wb_addr/wb_data valid with it
//   flag_z       zero flag (ALU ops only)
//   flag_c       carry (ADD/ADDI) or borrow (SUB); cleared by logic ops
//   retired      count of completed instructions, NOPs included (wraps)
//   dbg_addr     debug register select
//   dbg_data     combinational register read; r0 reads 0
// -----------------------------------------------------------------------------
module instruction_executor #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [31:0]       instruction,
    output logic              fetch_en,
    output logic              busy,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic [CNT_W-1:0]  retired,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    state_t              state_reg, state_next;
    logic [31:0]         ir_reg;
    logic [DATA_W-1:0]   result_reg;
    logic [4:0]          dest_reg;
    logic                wr_en_reg;
    logic                flag_z_reg, flag_c_reg;
    logic [CNT_W-1:0]    retired_reg;
    logic [DATA_W-1:0]   reg_file [32];

    // Instruction fields
    logic [2:0]          op;
    logic [4:0]          rs1, rs2, rd_r, rd_i;
    logic [DATA_W-1:0]   imm_ext;
    assign op      = ir_reg[31:29];
    assign rs1     = ir_reg[28:24];
    assign rs2     = ir_reg[23:19];
    assign rd_r    = ir_reg[18:14];
    assign rd_i    = ir_reg[23:19];
    assign imm_ext = {{(DATA_W-16){1'b0}}, ir_reg[15:0]};

    // Operand read happens in EXEC, one cycle before the WB write, so a
    // source equal to the destination always sees the old value.
    logic [DATA_W-1:0]   op_a, op_b, add_rhs;
    logic [DATA_W:0]     add_full, sub_full;
    assign op_a     = reg_file[rs1];
    assign op_b     = reg_file[rs2];
    assign add_rhs  = (op == OP_ADDI) ? imm_ext : op_b;
    assign add_full = {1'b0, op_a} + {1'b0, add_rhs};
    // Top bit of the extended difference is the unsigned borrow.
    assign sub_full = {1'b0, op_a} - {1'b0, op_b};

    logic [DATA_W-1:0]   alu_result;
    logic [4:0]          alu_dest;
    logic                alu_wr_en;
    logic                alu_flags_upd;
    logic                alu_c;

    always_comb begin
        alu_result    = '0;
        alu_dest      = rd_r;
        alu_wr_en     = 1'b1;
        alu_flags_upd = 1'b1;
        alu_c         = 1'b0;
        case (op)
            OP_NOP: begin
                alu_wr_en     = 1'b0;
                alu_flags_upd = 1'b0;
            end
            OP_XOR: alu_result = op_a ^ op_b;
            OP_ADD: begin
                alu_result = add_full[DATA_W-1:0];
                alu_c      = add_full[DATA_W];
            end
            OP_AND: alu_result = op_a & op_b;
            OP_SUB: begin
                alu_result = sub_full[DATA_W-1:0];
                alu_c      = sub_full[DATA_W];
            end
            OP_OR:  alu_result = op_a | op_b;
            OP_LI: begin
                alu_result    = imm_ext;
                alu_dest      = rd_i;
                alu_flags_upd = 1'b0;
            end
            default: begin // OP_ADDI
                alu_result = add_full[DATA_W-1:0];
                alu_c      = add_full[DATA_W];
                alu_dest   = rd_i;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and control outputs. fetch_en/busy/wb_valid decode the
    // state register directly, so they fall as soon as reset asserts.
    always_comb begin
        state_next = state_reg;
        fetch_en   = 1'b0;
        busy       = 1'b1;
        wb_valid   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_next = S_REQ;
            end
            S_REQ: begin
                fetch_en   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB: begin
                wb_valid   = wr_en_reg;
                state_next = run ? S_REQ : S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_reg      <= '0;
            result_reg  <= '0;
            dest_reg    <= '0;
            wr_en_reg   <= 1'b0;
            flag_z_reg  <= 1'b0;
            flag_c_reg  <= 1'b0;
            retired_reg <= '0;
        end else begin
            if (state_reg == S_DECODE) begin
                ir_reg <= instruction;
            end
            if (state_reg == S_EXEC) begin
                result_reg <= alu_result;
                dest_reg   <= alu_dest;
                wr_en_reg  <= alu_wr_en;
                if (alu_flags_upd) begin
                    flag_z_reg <= (alu_result == '0);
                    flag_c_reg <= alu_c;
                end
            end
            if (state_reg == S_WB) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    // Register file; r0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                reg_file[i] <= '0;
            end
        end else if (state_reg == S_WB && wr_en_reg && dest_reg != 5'd0) begin
            reg_file[dest_reg] <= result_reg;
        end
    end

    assign wb_addr  = dest_reg;
    assign wb_data  = result_reg;
    assign flag_z   = flag_z_reg;
    assign flag_c   = flag_c_reg;
    assign retired  = retired_reg;
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : reg_file[dbg_addr];

endmodule

// File: tb/tb_instruction_executor.sv
// -----------------------------------------------------------------------------
// tb_instruction_executor
//   Models a registered fetch unit feeding a program into the executor.
//   Each instruction issued by the fetch model pushes its expected write-back
//   into a queue; a negedge monitor pops and compares on every wb_valid and
//   checks fetch_en spacing and fetch-to-write-back latency.
// -----------------------------------------------------------------------------
module tb_instruction_executor;

    logic        clk;
    logic        reset;
    logic        run;
    logic [31:0] instruction;
    logic        fetch_en;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flag_z;
    logic        flag_c;
    logic [15:0] retired;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    instruction_executor #(.DATA_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instruction (instruction),
        .fetch_en    (fetch_en),
        .busy        (busy),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .retired     (retired),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t         exp_q [$];
    logic [31:0] prog_mem  [0:31];
    bit          prog_wb   [0:31];
    logic [4:0]  prog_addr [0:31];
    logic [31:0] prog_data [0:31];
    int          n_prog = 0;
    int          pc = 0;

    int vectors     = 0;
    int miscompares = 0;
    int fetch_cnt   = 0;
    int cyc         = 0;
    int last_fetch  = 0;
    bit have_fetch  = 0;
    bit idle_seen   = 1;

    function automatic logic [31:0] r_type(input logic [2:0] op, input logic [4:0] a,
                                           input logic [4:0] b, input logic [4:0] d);
        r_type = {op, a, b, d, 14'd0};
    endfunction

    function automatic logic [31:0] i_type(input logic [2:0] op, input logic [4:0] a,
                                           input logic [4:0] d, input logic [15:0] imm);
        i_type = {op, a, d, 3'd0, imm};
    endfunction

    task automatic add_instr(input logic [31:0] w, input bit has_wb,
                             input logic [4:0] a, input logic [31:0] d);
        prog_mem[n_prog]  = w;
        prog_wb[n_prog]   = has_wb;
        prog_addr[n_prog] = a;
        prog_data[n_prog] = d;
        n_prog++;
    endtask

    // Registered fetch unit: word appears the cycle after fetch_en, zero otherwise.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= '0;
        end else if (fetch_en) begin
            instruction <= prog_mem[pc];
            if (prog_wb[pc]) exp_q.push_back('{addr: prog_addr[pc], data: prog_data[pc]});
            pc <= pc + 1;
        end else begin
            instruction <= '0;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (!busy) idle_seen = 1;
            if (fetch_en) begin
                fetch_cnt++;
                if (have_fetch && !idle_seen) begin
                    vectors++;
                    if (cyc - last_fetch != 4) begin
                        miscompares++;
                        $display("FAIL fetch_spacing: got %0d cycles, expected 4", cyc - last_fetch);
                    end
                end
                last_fetch = cyc;
                have_fetch = 1;
                idle_seen  = 0;
            end
            if (wb_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wb_unexpected: got addr=%0d data=%h, expected no write-back",
                             wb_addr, wb_data);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    if (wb_addr !== e.addr || wb_data !== e.data || cyc - last_fetch != 3) begin
                        miscompares++;
                        $display("FAIL wb: got addr=%0d data=%h lat=%0d, expected addr=%0d data=%h lat=3",
                                 wb_addr, wb_data, cyc - last_fetch, e.addr, e.data);
                    end else begin
                        $display("wb addr=%0d data=%h ok", wb_addr, wb_data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("r%0d", a), dbg_data, exp);
    endtask

    task automatic chk_flags(input string name, input logic z, input logic c);
        chk({name, "_z"}, {31'd0, flag_z}, {31'd0, z});
        chk({name, "_c"}, {31'd0, flag_c}, {31'd0, c});
    endtask

    task automatic timeout(input string name);
        miscompares++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Run n instructions, dropping run during EXEC of the last one.
    task automatic run_instrs(input int n);
        int seen;
        int t;
        seen = 0;
        t    = 0;
        run  = 1'b1;
        while (seen < n && t < 200) begin
            @(negedge clk);
            t++;
            if (fetch_en) seen++;
        end
        if (seen < n) timeout("run_fetch");
        @(negedge clk);   // DECODE
        @(negedge clk);   // EXEC
        run = 1'b0;
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (busy) timeout("run_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset    = 1'b0;
        run      = 1'b0;
        dbg_addr = '0;

        // Main program
        add_instr(i_type(3'b110, 5'd0, 5'd10, 16'd10), 1, 5'd10, 32'd10);
        add_instr(i_type(3'b110, 5'd0, 5'd15, 16'd15), 1, 5'd15, 32'd15);
        add_instr(r_type(3'b010, 5'd10, 5'd15, 5'd25), 1, 5'd25, 32'd25);
        add_instr(i_type(3'b111, 5'd25, 5'd20, 16'd5), 1, 5'd20, 32'd30);
        add_instr(i_type(3'b110, 5'd0, 5'd5, 16'd2),   1, 5'd5,  32'd2);
        add_instr(r_type(3'b100, 5'd25, 5'd5, 5'd30),  1, 5'd30, 32'd23);
        // Flags
        add_instr(i_type(3'b110, 5'd0, 5'd1, 16'd5),   1, 5'd1,  32'd5);
        add_instr(i_type(3'b110, 5'd0, 5'd2, 16'd5),   1, 5'd2,  32'd5);
        add_instr(r_type(3'b100, 5'd1, 5'd2, 5'd3),    1, 5'd3,  32'd0);
        add_instr(r_type(3'b100, 5'd3, 5'd1, 5'd4),    1, 5'd4,  32'hFFFF_FFFB);
        add_instr(i_type(3'b110, 5'd0, 5'd6, 16'hFFFF), 1, 5'd6, 32'h0000_FFFF);
        add_instr(i_type(3'b111, 5'd4, 5'd7, 16'd5),   1, 5'd7,  32'd0);
        // r0 and NOP
        add_instr(i_type(3'b110, 5'd0, 5'd0, 16'd7),   1, 5'd0,  32'd7);
        add_instr(32'd0,                               0, 5'd0,  32'd0);
        // Logic ops, stopped mid-run
        add_instr(r_type(3'b001, 5'd10, 5'd15, 5'd11), 1, 5'd11, 32'd5);
        add_instr(r_type(3'b011, 5'd10, 5'd15, 5'd12), 1, 5'd12, 32'd10);
        add_instr(r_type(3'b101, 5'd10, 5'd15, 5'd13), 1, 5'd13, 32'd15);
        // Aborted by reset
        add_instr(r_type(3'b010, 5'd10, 5'd15, 5'd9),  1, 5'd9,  32'd25);

        // Reset / idle
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_ctrl_%0d", i), {29'd0, fetch_en, busy, wb_valid}, 32'd0);
        end
        chk("reset_retired", {16'd0, retired}, 32'd0);
        chk_flags("reset_flags", 1'b0, 1'b0);
        for (int a = 0; a < 32; a++) chk_reg(5'(a), 32'd0);

        // Main program
        run_instrs(6);
        chk_reg(5'd10, 32'd10);
        chk_reg(5'd15, 32'd15);
        chk_reg(5'd25, 32'd25);
        chk_reg(5'd20, 32'd30);
        chk_reg(5'd5,  32'd2);
        chk_reg(5'd30, 32'd23);
        chk("prog_retired", {16'd0, retired}, 32'd6);
        chk_flags("prog_flags", 1'b0, 1'b0);

        // Flags
        run_instrs(3);
        chk_reg(5'd3, 32'd0);
        chk_flags("sub_zero", 1'b1, 1'b0);
        run_instrs(1);
        chk_reg(5'd4, 32'hFFFF_FFFB);
        chk_flags("sub_borrow", 1'b0, 1'b1);
        run_instrs(1);
        chk_flags("li_keeps", 1'b0, 1'b1);
        run_instrs(1);
        chk_reg(5'd7, 32'd0);
        chk_flags("addi_carry", 1'b1, 1'b1);

        // Register 0 and NOP
        run_instrs(1);
        chk_reg(5'd0, 32'd0);
        run_instrs(1);
        chk("nop_retired", {16'd0, retired}, 32'd14);
        chk_flags("nop_flags", 1'b1, 1'b1);

        // Stop mid-run
        run_instrs(3);
        repeat (8) @(negedge clk);
        chk("stop_fetches", 32'(fetch_cnt), 32'd17);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_retired", {16'd0, retired}, 32'd17);
        chk_reg(5'd11, 32'd5);
        chk_reg(5'd12, 32'd10);
        chk_reg(5'd13, 32'd15);
        chk_flags("logic_flags", 1'b0, 1'b0);

        // Reset during EXEC of ADD r9
        run = 1'b1;
        t = 0;
        @(negedge clk);
        while (!fetch_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!fetch_en) timeout("abort_fetch");
        @(negedge clk);   // DECODE
        @(negedge clk);   // EXEC
        reset = 1'b0;
        #1;
        chk("abort_ctrl", {29'd0, fetch_en, busy, wb_valid}, 32'd0);
        chk("abort_retired", {16'd0, retired}, 32'd0);
        chk_flags("abort_flags", 1'b0, 1'b0);
        chk_reg(5'd9, 32'd0);
        chk_reg(5'd10, 32'd0);
        exp_q.delete();
        run = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_abort_busy", {31'd0, busy}, 32'd0);
        chk_reg(5'd9, 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
